// File: rtl/button_debounce_conditioner.sv
// button_debounce_conditioner: per-bit synchronise, debounce, press-pulse and press-toggle for PIO button inputs.
// out_port presents either the debounced level or the toggled pause flag to the PIO in_port.
module button_debounce_conditioner #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter bit OUT_MODE        = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] toggle_clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] toggle,
    output logic [WIDTH-1:0] out_port
);
    localparam logic [WIDTH-1:0]     IDLE = {WIDTH{ACTIVE_LOW}};
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] s1_q, s2_q, norm, accept;
    logic [WIDTH-1:0] level_q, level_d, pulse_q, pulse_d, toggle_q, toggle_d;
    logic [WIDTH-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
    assign norm = s2_q ^ IDLE;
    // A bit whose normalised input matches its level holds its counter at zero, so any bounce restarts it.
    always_comb begin
        accept = '0;
        cnt_d  = '0;
        for (int b = 0; b < WIDTH; b++) begin
            accept[b] = (norm[b] != level_q[b]) && (cnt_q[b] == LAST);
            cnt_d[b]  = (norm[b] == level_q[b] || accept[b]) ? '0 : cnt_q[b] + CNT_WIDTH'(1);
        end
        level_d  = level_q ^ accept;
        pulse_d  = accept & norm;
        toggle_d = ~toggle_clr & (toggle_q ^ pulse_d);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= IDLE;
            s2_q     <= IDLE;
            cnt_q    <= '0;
            level_q  <= '0;
            pulse_q  <= '0;
            toggle_q <= '0;
        end else begin
            s1_q     <= raw_in;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            toggle_q <= toggle_d;
        end
    end
    assign level       = level_q;
    assign press_pulse = pulse_q;
    assign toggle      = toggle_q;
    assign out_port    = OUT_MODE ? toggle_q : level_q;
endmodule
